// File: rtl/reg_op_sequencer_pkg.sv
// Shared definitions for the register-to-register operation sequencer:
// opcode and FSM encodings, plus default datapath widths.
package reg_op_sequencer_pkg;

    localparam int unsigned DEF_DATA_W = 4;
    localparam int unsigned DEF_ADDR_W = 2;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_MOV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_READ  = 2'b01,
        S_EXEC  = 2'b10,
        S_WRITE = 2'b11
    } state_e;

endpackage

// File: rtl/reg_op_sequencer_alu.sv
// Combinational ALU: computes the result and carry/borrow for one operation
// from the two captured operands.
module reg_op_alu
    import reg_op_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic [1:0]        op_code,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W:0] sum;

    always_comb begin
        sum    = '0;
        result = '0;
        carry  = 1'b0;
        case (op_e'(op_code))
            OP_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            OP_SUB: begin
                // Borrow is the unsigned a < b comparison
                result = a - b;
                carry  = (a < b);
            end
            OP_AND: result = a & b;
            OP_MOV: result = a;
            default: result = a;
        endcase
    end

endmodule

// File: rtl/reg_op_sequencer.sv
// Four-state sequencer driving a register file through one operation at a
// time: read two sources, compute, write back one destination.
module reg_op_sequencer
    import reg_op_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        op_code,
    input  logic [ADDR_W-1:0] op_ra,
    input  logic [ADDR_W-1:0] op_rb,
    input  logic [ADDR_W-1:0] op_rd,
    output logic [ADDR_W-1:0] rf_ra,
    output logic [ADDR_W-1:0] rf_rb,
    input  logic [DATA_W-1:0] rf_rdata_a,
    input  logic [DATA_W-1:0] rf_rdata_b,
    output logic [ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_we,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              flag_z,
    output logic              flag_c
);

    state_e            state;
    logic [1:0]        code_q;
    logic [DATA_W-1:0] opa_q;
    logic [DATA_W-1:0] opb_q;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;

    reg_op_alu #(.DATA_W(DATA_W)) u_alu (
        .op_code (code_q),
        .a       (opa_q),
        .b       (opb_q),
        .result  (alu_result),
        .carry   (alu_carry)
    );

    // Write data is the held result register, so it is never X
    assign rf_wdata = result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            op_ready <= 1'b1;
            rf_we    <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            flag_z   <= 1'b0;
            flag_c   <= 1'b0;
            code_q   <= 2'b00;
            opa_q    <= '0;
            opb_q    <= '0;
            rf_ra    <= '0;
            rf_rb    <= '0;
            rf_wa    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (op_valid && op_ready) begin
                        code_q   <= op_code;
                        rf_ra    <= op_ra;
                        rf_rb    <= op_rb;
                        rf_wa    <= op_rd;
                        op_ready <= 1'b0;
                        state    <= S_READ;
                    end
                end
                S_READ: begin
                    opa_q <= rf_rdata_a;
                    opb_q <= rf_rdata_b;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    result <= alu_result;
                    flag_z <= (alu_result == '0);
                    flag_c <= alu_carry;
                    rf_we  <= 1'b1;
                    done   <= 1'b1;
                    state  <= S_WRITE;
                end
                S_WRITE: begin
                    rf_we    <= 1'b0;
                    done     <= 1'b0;
                    op_ready <= 1'b1;
                    state    <= S_IDLE;
                end
                default: begin
                    rf_we    <= 1'b0;
                    done     <= 1'b0;
                    op_ready <= 1'b1;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Directed bench for reg_op_sequencer with a behavioural 4x4 register file.
module tb_reg_op_sequencer;

    logic       clk;
    logic       rst;
    logic       op_valid;
    logic       op_ready;
    logic [1:0] op_code;
    logic [1:0] op_ra;
    logic [1:0] op_rb;
    logic [1:0] op_rd;
    logic [1:0] rf_ra;
    logic [1:0] rf_rb;
    logic [3:0] rf_rdata_a;
    logic [3:0] rf_rdata_b;
    logic [1:0] rf_wa;
    logic [3:0] rf_wdata;
    logic       rf_we;
    logic       done;
    logic [3:0] result;
    logic       flag_z;
    logic       flag_c;

    int checks;
    int failures;

    logic [3:0] rf [4];

    reg_op_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_code    (op_code),
        .op_ra      (op_ra),
        .op_rb      (op_rb),
        .op_rd      (op_rd),
        .rf_ra      (rf_ra),
        .rf_rb      (rf_rb),
        .rf_rdata_a (rf_rdata_a),
        .rf_rdata_b (rf_rdata_b),
        .rf_wa      (rf_wa),
        .rf_wdata   (rf_wdata),
        .rf_we      (rf_we),
        .done       (done),
        .result     (result),
        .flag_z     (flag_z),
        .flag_c     (flag_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file model, reset together with the sequencer
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rf[0] <= 4'b0001;
            rf[1] <= 4'b0010;
            rf[2] <= 4'b0100;
            rf[3] <= 4'b1000;
        end else if (rf_we) begin
            rf[rf_wa] <= rf_wdata;
        end
    end

    assign rf_rdata_a = rf[rf_ra];
    assign rf_rdata_b = rf[rf_rb];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        op_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One full operation, accepted on the next edge; fields are scrambled
    // right after the accept to show only the latched copy is used.
    task automatic run_op(input string tag, input logic [1:0] code, input logic [1:0] ra,
                          input logic [1:0] rb, input logic [1:0] rd,
                          input logic [3:0] exp, input logic exp_z, input logic exp_c);
        chk({tag, "_ready_idle"}, op_ready, 1);
        op_valid = 1'b1;
        op_code = code;
        op_ra = ra;
        op_rb = rb;
        op_rd = rd;
        tick();
        op_valid = 1'b0;
        op_code = ~code;
        op_ra = ~ra;
        op_rb = ~rb;
        op_rd = ~rd;
        chk({tag, "_ready_read"}, op_ready, 0);
        chk({tag, "_rf_ra"}, rf_ra, ra);
        chk({tag, "_rf_rb"}, rf_rb, rb);
        chk({tag, "_we_read"}, rf_we, 0);
        op_valid = 1'b1;
        tick();
        chk({tag, "_we_exec"}, rf_we, 0);
        chk({tag, "_done_exec"}, done, 0);
        op_valid = 1'b0;
        tick();
        chk({tag, "_we_write"}, rf_we, 1);
        chk({tag, "_done_write"}, done, 1);
        chk({tag, "_wa"}, rf_wa, rd);
        chk({tag, "_wdata"}, rf_wdata, exp);
        chk({tag, "_flag_z"}, flag_z, exp_z);
        chk({tag, "_flag_c"}, flag_c, exp_c);
        tick();
        chk({tag, "_we_after"}, rf_we, 0);
        chk({tag, "_done_after"}, done, 0);
        chk({tag, "_ready_after"}, op_ready, 1);
        chk({tag, "_result_held"}, result, exp);
        chk({tag, "_rf_dest"}, rf[rd], exp);
    endtask

    logic [1:0] bb_code [3] = '{2'b00, 2'b00, 2'b01};
    logic [1:0] bb_ra   [3] = '{2'd0, 2'd2, 2'd3};
    logic [1:0] bb_rb   [3] = '{2'd1, 2'd2, 2'd0};
    logic [1:0] bb_rd   [3] = '{2'd2, 2'd3, 2'd0};
    logic [3:0] bb_exp  [3] = '{4'h3, 4'h6, 4'h5};

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        op_valid = 1'b0;
        op_code = 2'b00;
        op_ra = 2'd0;
        op_rb = 2'd0;
        op_rd = 2'd0;
        #2;
        chk("rst_ready", op_ready, 1);
        chk("rst_we", rf_we, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_flag_z", flag_z, 0);
        chk("rst_flag_c", flag_c, 0);
        tick();
        tick();
        rst = 1'b0;

        // 1+2, then 1-2 wraps with borrow, then F+1 wraps to zero with carry
        run_op("add", 2'b00, 2'd0, 2'd1, 2'd2, 4'h3, 1'b0, 1'b0);
        run_op("sub", 2'b01, 2'd0, 2'd1, 2'd3, 4'hF, 1'b0, 1'b1);
        run_op("add_wrap", 2'b00, 2'd3, 2'd0, 2'd3, 4'h0, 1'b1, 1'b1);

        reset_dut();
        run_op("and", 2'b10, 2'd0, 2'd1, 2'd0, 4'h0, 1'b1, 1'b0);
        run_op("mov", 2'b11, 2'd3, 2'd2, 2'd1, 4'h8, 1'b0, 1'b0);
        chk("mov_r0_kept", rf[0], 4'h0);

        // op_valid held high across three back-to-back operations
        reset_dut();
        op_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k % 4 == 0) begin
                op_code = bb_code[k/4];
                op_ra = bb_ra[k/4];
                op_rb = bb_rb[k/4];
                op_rd = bb_rd[k/4];
            end else if (k % 4 == 1) begin
                op_code = 2'b11;
                op_ra = 2'd1;
                op_rb = 2'd1;
                op_rd = 2'd1;
            end
            chk($sformatf("bb_ready_%0d", k), op_ready, (k % 4 == 0) ? 1 : 0);
            chk($sformatf("bb_done_%0d", k), done, (k % 4 == 3) ? 1 : 0);
            if (k % 4 == 3) begin
                chk($sformatf("bb_wdata_%0d", k), rf_wdata, bb_exp[k/4]);
                chk($sformatf("bb_wa_%0d", k), rf_wa, bb_rd[k/4]);
            end
            tick();
        end
        op_valid = 1'b0;
        chk("bb_ready_end", op_ready, 1);
        chk("bb_r0", rf[0], 4'h5);
        chk("bb_r1", rf[1], 4'h2);
        chk("bb_r2", rf[2], 4'h3);
        chk("bb_r3", rf[3], 4'h6);

        // Reset asserted mid-EXEC aborts the write
        reset_dut();
        op_valid = 1'b1;
        op_code = 2'b01;
        op_ra = 2'd0;
        op_rb = 2'd1;
        op_rd = 2'd2;
        tick();
        op_valid = 1'b0;
        tick();
        chk("abort_in_exec_we", rf_we, 0);
        rst = 1'b1;
        #1;
        chk("abort_ready", op_ready, 1);
        chk("abort_result", result, 0);
        for (int k = 0; k < 6; k++) begin
            if (k == 2) rst = 1'b0;
            chk($sformatf("abort_we_%0d", k), rf_we, 0);
            chk($sformatf("abort_done_%0d", k), done, 0);
            tick();
        end
        chk("abort_ready_after", op_ready, 1);
        chk("abort_result_after", result, 0);
        chk("abort_r2", rf[2], 4'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_op_sequencer.md
# reg_op_sequencer

Multi-cycle controller that sequences the 4-entry × 4-bit register file through one register-to-register operation at a time: read two sources, compute, write back one destination. It sits between the instruction source (op handshake) and the register file's two read-address ports and single write port, and is the only driver of the register file's write enable.

## Interface
- DATA_W, 4, register data width
- ADDR_W, 2, register address width (2^ADDR_W registers)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- op_valid  in  1  operation offered
- op_ready  out  1  sequencer can accept an operation
- op_code  in  2  00 ADD, 01 SUB, 10 AND, 11 MOV
- op_ra  in  ADDR_W  source A register
- op_rb  in  ADDR_W  source B register (ignored for MOV)
- op_rd  in  ADDR_W  destination register
- rf_ra  out  ADDR_W  register file read address A
- rf_rb  out  ADDR_W  register file read address B
- rf_rdata_a  in  DATA_W  register file read data A (combinational from rf_ra)
- rf_rdata_b  in  DATA_W  register file read data B (combinational from rf_rb)
- rf_wa  out  ADDR_W  register file write address
- rf_wdata  out  DATA_W  register file write data
- rf_we  out  1  register file write enable
- done  out  1  one-cycle pulse, operation written back
- result  out  DATA_W  last computed result, held until next EXEC
- flag_z  out  1  result == 0, held with result
- flag_c  out  1  ADD carry-out / SUB borrow; 0 for AND, MOV

## Operation
- FSM states: IDLE, READ, EXEC, WRITE; fixed order, no skipping, no stall.
- IDLE: op_ready = 1. On op_valid & op_ready: latch op_code, op_ra, op_rb, op_rd; go READ. Else stay.
- READ: rf_ra/rf_rb driven from latched fields; capture rf_rdata_a/b into operand registers at cycle end; go EXEC.
- EXEC: compute from captured operands into result/flag_z/flag_c; go WRITE.
- WRITE: rf_we = 1, rf_wa = latched rd, rf_wdata = result; done = 1; go IDLE.
- op_ready = 0 in READ, EXEC, WRITE; op_valid ignored there (fields may change freely).
- Arithmetic, all modulo 2^DATA_W: ADD a+b, flag_c = bit DATA_W of (DATA_W+1)-bit sum; SUB a−b, flag_c = 1 iff a < b (unsigned); AND a&b; MOV a.
- rd equal to ra or rb is legal: operands already captured in READ, so write uses old values.
- rf_ra/rf_rb hold latched addresses outside READ; rf_wa/rf_wdata are don't-care when rf_we = 0 but driven from registers (no X).
- Reset: state → IDLE immediately; rf_we, done, result, flag_z, flag_c, operand and latched-field registers → 0; op_ready = 1 while and after reset. Reset in any state aborts the operation with no write; rf_we falls asynchronously.

## Timing
- Accept at edge N (end of IDLE cycle) → READ cycle N+1 → EXEC N+2 → WRITE N+3; write lands in register file at edge ending N+3; done high during N+3.
- Earliest next accept: IDLE cycle N+4; sustained throughput one op per 4 cycles with op_valid held high.
- Next op reading a just-written register sees the new value (write lands before its READ).
- rf_we and done are Moore outputs of WRITE; op_ready is a Moore output of IDLE (no combinational path from op_valid).

## Structure
- Shared package: opcode constants (OP_ADD, OP_SUB, OP_AND, OP_MOV), FSM state encoding, DATA_W/ADDR_W defaults.
- One natural sub-module: reg_op_alu, combinational (op_code, a, b → result, carry); FSM and registers stay in reg_op_sequencer.

## Test plan
Register file reset contents r0=0001, r1=0010, r2=0100, r3=1000; reset both blocks together.
- ADD ra=0 rb=1 rd=2 → rf_we one cycle, rf_wa=2, rf_wdata=0011, done 3 cycles after accept, flag_z=0, flag_c=0; r2 reads 0011.
- SUB ra=0 rb=1 rd=3 → rf_wdata=1111, flag_c=1; then ADD ra=3 rb=0 rd=3 → 0000, flag_z=1, flag_c=1.
- AND ra=0 rb=1 rd=0 then MOV ra=3 rd=1 → r0=0000, r1=1000, flag_c=0 both.
- op_valid held high with 3 back-to-back ops → accepts exactly every 4 cycles, op_ready low in READ/EXEC/WRITE, second op reading first op's rd sees new value.
- Assert rst during EXEC → rf_we never asserts, done stays 0, op_ready=1 and result=0000 after reset; target register unchanged.
- Change op fields while op_ready=0 → written result reflects fields latched at accept only.
